// File: rtl/edm_obi_stream_fetcher_pkg.sv
// Shared types for the EDM OBI stream fetcher: FSM states, default sizing, OBI structs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   fetcher_state_e        IDLE / FETCH / DRAIN / DONE
//   obi_cfg_t, MgrObiCfg   OBI address/data widths (32/32)
//   obi_req_t, obi_rsp_t   default manager request/response structs
//   word_align()           clears the byte-offset bits of an address
package edm_obi_stream_fetcher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetcher_state_e;

  localparam int unsigned DefaultFifoDepth      = 4;
  localparam int unsigned DefaultMaxOutstanding = 2;
  localparam int unsigned DefaultLenWidth       = 16;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
  } obi_cfg_t;

  localparam obi_cfg_t MgrObiCfg = '{AddrWidth: 32, DataWidth: 32};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/edm_stream_fifo.sv
// First-word-fall-through FIFO with occupancy count for the fetcher stream buffer.
// Latency: a pushed word is visible on pop_data/!empty the cycle after the push.
// Backpressure: pop is ignored while empty; push is accepted when not full or when popping.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write strobe and word
//   pop                 consumer takes the head word (ignored when empty)
//   pop_data, empty     head word and empty flag
//   count               number of stored words (0..Depth)
module edm_stream_fifo #(
  parameter  int unsigned Width = 32,
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign do_pop   = pop && !empty;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/edm_obi_stream_fetcher.sv
// OBI manager read streamer: fetches num_words consecutive words from base_addr into a FIFO stream.
// Latency: first request one cycle after an accepted start; words appear one cycle after rvalid.
// Backpressure: ready_i=0 stalls the stream; requests are throttled so the R channel never stalls.
//
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   start_i                     one-cycle start (ignored unless idle)
//   base_addr_i, num_words_i    transfer config, sampled on accepted start
//   obi_mgr_req_o/obi_mgr_rsp_i OBI manager A/R channels (read-only)
//   data_o, valid_o, ready_i    output word stream
//   busy_o, done_o, err_o       status: in progress, end pulse, sticky error
module edm_obi_stream_fetcher
  import edm_obi_stream_fetcher_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg         = MgrObiCfg,
  parameter type         mgr_obi_req_t  = obi_req_t,
  parameter type         mgr_obi_rsp_t  = obi_rsp_t,
  parameter int unsigned FifoDepth      = DefaultFifoDepth,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter int unsigned LenWidth       = DefaultLenWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [31:0]         base_addr_i,
  input  logic [LenWidth-1:0] num_words_i,
  output mgr_obi_req_t        obi_mgr_req_o,
  input  mgr_obi_rsp_t        obi_mgr_rsp_i,
  output logic [31:0]         data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int unsigned Aw   = ObiCfg.AddrWidth;
  localparam int unsigned Dw   = ObiCfg.DataWidth;
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  fetcher_state_e      state_q;
  fetcher_state_e      state_d;
  logic [Aw-1:0]       addr_q;
  logic                req_q;
  logic                req_d;
  logic [LenWidth-1:0] left_q;
  logic [LenWidth-1:0] left_d;
  logic [OutW-1:0]     out_q;
  logic [OutW-1:0]     out_d;
  logic                err_q;
  logic [CntW-1:0]     fifo_count;
  logic [CntW-1:0]     cnt_d;
  logic                fifo_empty;
  logic [Dw-1:0]       fifo_data;

  logic start_acc;
  logic gnt_fire;
  logic rv_fire;
  logic pop_fire;

  assign start_acc = start_i && (state_q == IDLE);
  assign gnt_fire  = req_q && obi_mgr_rsp_i.gnt;
  // A response with nothing outstanding belongs to a request from before a reset.
  assign rv_fire   = obi_mgr_rsp_i.rvalid && (out_q != '0);
  assign pop_fire  = valid_o && ready_i;

  // ---------------- stream buffer ----------------
  edm_stream_fifo #(
    .Width (Dw),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (rv_fire),
    .push_data (obi_mgr_rsp_i.r.rdata),
    .pop       (pop_fire),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign data_o  = fifo_data;
  assign valid_o = !fifo_empty;
  assign err_o   = err_q;

  // ---------------- OBI A channel ----------------
  assign obi_mgr_req_o.req     = req_q;
  assign obi_mgr_req_o.a.addr  = addr_q;
  assign obi_mgr_req_o.a.we    = 1'b0;
  assign obi_mgr_req_o.a.be    = 4'hF;
  assign obi_mgr_req_o.a.wdata = '0;

  // ---------------- next-cycle bookkeeping ----------------
  always_comb begin
    out_d = out_q;
    if (gnt_fire && !rv_fire)      out_d = out_q + OutW'(1);
    else if (!gnt_fire && rv_fire) out_d = out_q - OutW'(1);
  end

  always_comb begin
    cnt_d = fifo_count;
    if (rv_fire && !pop_fire)      cnt_d = fifo_count + CntW'(1);
    else if (!rv_fire && pop_fire) cnt_d = fifo_count - CntW'(1);
  end

  always_comb begin
    left_d = left_q;
    if (start_acc)     left_d = num_words_i;
    else if (gnt_fire) left_d = left_q - LenWidth'(1);
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_acc) state_d = (num_words_i == '0) ? DONE : FETCH;
      FETCH:   if (gnt_fire && (left_q == LenWidth'(1))) state_d = DRAIN;
      // Looking at next-cycle counts lets done follow the final pop directly.
      DRAIN:   if ((out_d == '0) && (cnt_d == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_o = (state_q == FETCH) || (state_q == DRAIN);
    done_o = (state_q == DONE);
  end

  // Issue decision. A pending request is held until granted; otherwise a new one
  // is raised only if its response is guaranteed a FIFO slot, counting every
  // outstanding read against the words already buffered.
  always_comb begin
    req_d = 1'b0;
    if (req_q && !gnt_fire) begin
      req_d = 1'b1;
    end else if ((state_d == FETCH) && (left_d != '0) &&
                 ((32'(out_d) + 32'(cnt_d)) < FifoDepth) &&
                 (32'(out_d) < MaxOutstanding)) begin
      req_d = 1'b1;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      req_q  <= 1'b0;
      left_q <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      req_q  <= req_d;
      left_q <= left_d;
      out_q  <= out_d;
      if (start_acc) begin
        addr_q <= Aw'(word_align(base_addr_i));
        err_q  <= 1'b0;
      end else begin
        if (gnt_fire) addr_q <= addr_q + Aw'(4);
        if (rv_fire && obi_mgr_rsp_i.r.err) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_edm_obi_stream_fetcher.sv
module tb_edm_obi_stream_fetcher;
  import edm_obi_stream_fetcher_pkg::*;

  localparam int Depth  = DefaultFifoDepth;
  localparam int MaxOut = DefaultMaxOutstanding;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] num_words_i;
  obi_req_t    obi_req;
  obi_rsp_t    obi_rsp;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  edm_obi_stream_fetcher dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .num_words_i   (num_words_i),
    .obi_mgr_req_o (obi_req),
    .obi_mgr_rsp_i (obi_rsp),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  // Subordinate: in-order responses, each due a random number of cycles after grant.
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  int vectors, miscompares, cyc;
  int gnt_pct, rdy_pct, lat_max, last_due;
  bit hold_rsp;
  logic [31:0] err_mask, salt;
  int grant_idx, n_resp, n_pop, n_done, done_cyc, last_pop_cyc, first_req_cyc, start_cyc;
  int max_out, max_occ;
  bit done_busy;
  logic [31:0] exp_base;
  int exp_n;

  // Memory contents as seen by the subordinate.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ salt;
  endfunction

  // One clock: drive subordinate/consumer from the current outputs, record events, advance.
  task automatic step();
    logic  g, rv;
    pend_t e;
    int    occ, d;
    g  = obi_req.req && (int'($urandom_range(99)) < gnt_pct);
    rv = !hold_rsp && (pend.size() > 0) && (pend[0].due <= cyc);
    obi_rsp.gnt     = g;
    obi_rsp.rvalid  = rv;
    obi_rsp.r.rdata = rv ? pend[0].data : $urandom();
    obi_rsp.r.err   = rv ? pend[0].err : 1'b0;
    ready_i = (int'($urandom_range(99)) < rdy_pct);
    occ = n_resp - n_pop;
    if (pend.size() > max_out) max_out = pend.size();
    if (pend.size() + occ > max_occ) max_occ = pend.size() + occ;
    if (obi_req.req && first_req_cyc < 0) first_req_cyc = cyc;
    if (rv) begin
      void'(pend.pop_front());
      n_resp++;
    end
    if (g) begin
      d = cyc + int'($urandom_range(lat_max, 1));
      if (d < last_due) d = last_due;
      last_due = d;
      e.data = mem_word(obi_req.a.addr);
      e.err  = (grant_idx < 32) ? err_mask[grant_idx] : 1'b0;
      e.due  = d;
      pend.push_back(e);
      got_addr.push_back(obi_req.a.addr);
      grant_idx++;
    end
    if (valid_o && ready_i) begin
      got_data.push_back(data_o);
      n_pop++;
      last_pop_cyc = cyc;
    end
    if (done_o) begin
      n_done++;
      done_cyc  = cyc;
      done_busy = busy_o;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_xfer(input logic [31:0] base, input int n);
    got_addr.delete();
    got_data.delete();
    grant_idx = 0; n_resp = 0; n_pop = 0; n_done = 0;
    done_cyc = -1; last_pop_cyc = -1; first_req_cyc = -1;
    max_out = 0; max_occ = 0; done_busy = 1'b0;
    exp_base = base & ~32'h3;
    exp_n    = n;
    start_i     = 1'b1;
    base_addr_i = base;
    num_words_i = 16'(n);
    start_cyc   = cyc;
    step();
    start_i     = 1'b0;
    base_addr_i = $urandom();
    num_words_i = 16'($urandom());
  endtask

  // Runs the current transfer to completion and scores it against the reference:
  // addresses base+4i (mod 2^32), words mem[base+4i], one done pulse, err = any err injected.
  task automatic finish_xfer(input int limit);
    int          k;
    bit          exp_err;
    logic [31:0] ea;
    k = 0;
    while (n_done == 0 && k < limit) begin
      step();
      k++;
    end
    vectors++;
    if (n_done == 0) begin
      $display("FAIL done_timeout: no done_o within %0d cycles", limit);
      miscompares++;
    end
    repeat (3) step();
    exp_err = 1'b0;
    for (int i = 0; i < exp_n && i < 32; i++) if (err_mask[i]) exp_err = 1'b1;

    vectors++;
    if (n_done !== 1) begin
      $display("FAIL done_count: got %0d expected 1", n_done); miscompares++;
    end
    vectors++;
    if (done_busy !== 1'b0) begin
      $display("FAIL busy_on_done: got %0b expected 0", done_busy); miscompares++;
    end
    vectors++;
    if (got_addr.size() !== exp_n) begin
      $display("FAIL grant_count: got %0d expected %0d", got_addr.size(), exp_n); miscompares++;
    end
    for (int i = 0; i < exp_n && i < got_addr.size(); i++) begin
      ea = exp_base + 32'(4 * i);
      vectors++;
      if (got_addr[i] !== ea) begin
        $display("FAIL addr[%0d]: got %h expected %h", i, got_addr[i], ea); miscompares++;
      end
    end
    vectors++;
    if (got_data.size() !== exp_n) begin
      $display("FAIL word_count: got %0d expected %0d", got_data.size(), exp_n); miscompares++;
    end
    for (int i = 0; i < exp_n && i < got_data.size(); i++) begin
      ea = exp_base + 32'(4 * i);
      vectors++;
      if (got_data[i] !== mem_word(ea)) begin
        $display("FAIL data[%0d]: got %h expected %h", i, got_data[i], mem_word(ea)); miscompares++;
      end
    end
    vectors++;
    if (err_o !== exp_err) begin
      $display("FAIL err_o: got %b expected %b", err_o, exp_err); miscompares++;
    end
    vectors++;
    if (max_out > MaxOut || max_occ > Depth) begin
      $display("FAIL credit_bound: outstanding %0d (max %0d) out+buffered %0d (max %0d)",
               max_out, MaxOut, max_occ, Depth); miscompares++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    gnt_pct = 0; hold_rsp = 1'b1;
    repeat (3) step();
    rst_i = 1'b0; hold_rsp = 1'b0;
    vectors++;
    if (obi_req.req !== 1'b0 || obi_req.a.addr !== 32'h0) begin
      $display("FAIL reset_req: got req=%b addr=%h expected 0/0", obi_req.req, obi_req.a.addr); miscompares++;
    end
    vectors++;
    if ({valid_o, busy_o, done_o, err_o} !== 4'b0000) begin
      $display("FAIL reset_status: got v/b/d/e=%b expected 0000", {valid_o, busy_o, done_o, err_o}); miscompares++;
    end
    vectors++;
    if (obi_req.a.we !== 1'b0 || obi_req.a.be !== 4'hF || obi_req.a.wdata !== 32'h0) begin
      $display("FAIL a_chan_const: got we=%b be=%h wdata=%h expected 0/f/0",
               obi_req.a.we, obi_req.a.be, obi_req.a.wdata); miscompares++;
    end
  endtask

  task automatic test_basic();
    gnt_pct = 100; rdy_pct = 100; lat_max = 1; err_mask = 0;
    start_xfer(32'h1000_0000, 4);
    finish_xfer(200);
    vectors++;
    if (first_req_cyc !== start_cyc + 1) begin
      $display("FAIL first_req_latency: got cycle %0d expected %0d", first_req_cyc, start_cyc + 1); miscompares++;
    end
    vectors++;
    if (done_cyc !== last_pop_cyc + 1) begin
      $display("FAIL done_after_pop: got cycle %0d expected %0d", done_cyc, last_pop_cyc + 1); miscompares++;
    end
  endtask

  task automatic test_backpressure();
    gnt_pct = 100; rdy_pct = 0; lat_max = 3; err_mask = 0;
    start_xfer(32'h2000_0040, 8);
    repeat (40) step();
    vectors++;
    if (got_addr.size() !== Depth) begin
      $display("FAIL stalled_grants: got %0d expected %0d", got_addr.size(), Depth); miscompares++;
    end
    vectors++;
    if (obi_req.req !== 1'b0 || valid_o !== 1'b1) begin
      $display("FAIL stalled_state: got req=%b valid=%b expected 0/1", obi_req.req, valid_o); miscompares++;
    end
    rdy_pct = 100;
    finish_xfer(500);
  endtask

  task automatic test_gnt_stall();
    logic [31:0] a0;
    int          k;
    gnt_pct = 0; rdy_pct = 100; lat_max = 2; err_mask = 0;
    start_xfer(32'h3000_0100, 2);
    k = 0;
    while (!obi_req.req && k < 10) begin step(); k++; end
    a0 = obi_req.a.addr;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (obi_req.req !== 1'b1 || obi_req.a.addr !== a0) begin
        $display("FAIL stall_hold[%0d]: got req=%b addr=%h expected 1/%h", i, obi_req.req, obi_req.a.addr, a0);
        miscompares++;
      end
    end
    gnt_pct = 100;
    finish_xfer(200);
  endtask

  task automatic test_wrap_err();
    gnt_pct = 100; rdy_pct = 100; lat_max = 2; err_mask = 32'h2;
    start_xfer(32'hFFFF_FFF8, 3);
    finish_xfer(200);
  endtask

  task automatic test_zero_and_busy_start();
    gnt_pct = 100; rdy_pct = 100; lat_max = 1; err_mask = 0;
    start_xfer(32'h4000_0003, 0);
    vectors++;
    if (done_o !== 1'b1 || obi_req.req !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      $display("FAIL zero_len: got done=%b req=%b busy=%b err=%b expected 1/0/0/0",
               done_o, obi_req.req, busy_o, err_o); miscompares++;
    end
    finish_xfer(50);
    vectors++;
    if (done_cyc !== start_cyc + 1) begin
      $display("FAIL zero_done_cycle: got %0d expected %0d", done_cyc, start_cyc + 1); miscompares++;
    end
    gnt_pct = 50; lat_max = 3;
    start_xfer(32'h5000_0010, 4);
    step(); step();
    start_i = 1'b1; base_addr_i = 32'h6000_0000; num_words_i = 16'd9;
    step();
    start_i = 1'b0;
    finish_xfer(300);
  endtask

  task automatic test_reset_mid();
    int k;
    bit bad_v, bad_d, bad_b, bad_r;
    gnt_pct = 100; rdy_pct = 0; lat_max = 6; err_mask = 0;
    start_xfer(32'h7000_0000, 6);
    k = 0;
    while (pend.size() < 2 && k < 10) begin step(); k++; end
    vectors++;
    if (pend.size() !== 2) begin
      $display("FAIL outstanding_before_reset: got %0d expected 2", pend.size()); miscompares++;
    end
    rst_i = 1'b1; gnt_pct = 0; hold_rsp = 1'b1;
    step();
    rst_i = 1'b0; hold_rsp = 1'b0; rdy_pct = 100;
    bad_v = 0; bad_d = 0; bad_b = 0; bad_r = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid_o !== 1'b0) bad_v = 1;
      if (done_o !== 1'b0) bad_d = 1;
      if (busy_o !== 1'b0) bad_b = 1;
      if (obi_req.req !== 1'b0) bad_r = 1;
    end
    vectors++;
    if (bad_v) begin $display("FAIL stale_push: got valid_o=1 expected 0"); miscompares++; end
    vectors++;
    if (bad_d) begin $display("FAIL stale_done: got done_o=1 expected 0"); miscompares++; end
    vectors++;
    if (bad_b || bad_r) begin
      $display("FAIL after_reset_idle: got busy=%b req=%b expected 0/0", bad_b, bad_r); miscompares++;
    end
    pend.delete();
    last_due = 0;
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 6; t++) begin
      n       = int'($urandom_range(20, 1));
      gnt_pct = int'($urandom_range(100, 30));
      rdy_pct = int'($urandom_range(100, 20));
      lat_max = int'($urandom_range(4, 1));
      err_mask = ($urandom_range(2) == 0) ? (32'h1 << $urandom_range(n - 1)) : 32'h0;
      start_xfer($urandom(), n);
      finish_xfer(3000);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; last_due = 0;
    salt = $urandom();
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
    obi_rsp = '0; ready_i = 1'b0;
    gnt_pct = 0; rdy_pct = 0; lat_max = 1; hold_rsp = 1'b0; err_mask = 0;
    grant_idx = 0; n_resp = 0; n_pop = 0; n_done = 0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gnt_stall();
    test_wrap_err();
    test_zero_and_busy_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
